// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the 4-digit scanned 7-segment display.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
// Contents: active-low segment patterns {g,f,e,d,c,b,a}, converter FSM
// state encoding, and a digit-to-segment decoder (codes >9 show a dash).
package seg7_defs;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// Latency: start -> done = 9 clks (8 shift clks in CONV, result held in LOAD).
// Backpressure: start is ignored unless IDLE; caller must not restart while busy.
// Ports: clk, reset_n (async, active-low), start (1-clk pulse), bin[7:0]
//        -> busy (CONV/LOAD), done (high for the LOAD clk), bcd[11:0] {hund,tens,ones}.
module bin2bcd_seq
  import seg7_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q;
  logic [19:0] sr_q;      // {hund, tens, ones, binary}
  logic [2:0]  shift_q;
  logic        busy_q;
  logic        done_q;
  logic [19:0] adj;

  // Each BCD nibble >= 5 is pre-corrected by +3 so the following shift
  // carries correctly into the next decimal digit.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8 + 4*i +: 4] >= 4'd5) begin
        adj[8 + 4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= {12'd0, bin};
            shift_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          sr_q    <= {adj[18:0], 1'b0};
          shift_q <= shift_q + 3'd1;
          if (shift_q == 3'd7) begin
            done_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sr_q[19:8];

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed 7-segment driver: units digit plus decimal tally (0..255).
// Latency: frame tick -> new display values 10 clks; seg/an/dp follow digit_sel 1 clk after scan_tick.
// Backpressure: none; en=0 blanks the display and parks the scan at digit 0.
// Ports: clk, reset_n (async, active-low), en, count[3:0] (BCD units), tc[7:0] (binary tally)
//        -> seg[6:0] {g..a} active-low, dp active-low, an[3:0] one-hot-low, bin_busy, value_valid.
module seg7_scan_display
  import seg7_defs::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] count,
  input  logic [7:0] tc,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       bin_busy,
  output logic       value_valid
);

  localparam int PW = 20;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic          scan_tick, frame_tick;

  logic [3:0]  units_snap_q;
  logic [3:0]  disp_units_q, disp_ones_q, disp_tens_q, disp_hund_q;
  logic        value_valid_q;

  logic        conv_done;
  logic [11:0] conv_bcd;

  logic [3:0]  slot_val;
  logic        slot_blank;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  assign scan_tick  = en && (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_tick = scan_tick && (digit_sel_q == 2'd3);

  always_comb begin
    presc_d     = presc_q + PW'(1);
    digit_sel_d = digit_sel_q;
    if (!en) begin
      presc_d     = '0;
      digit_sel_d = 2'd0;
    end else if (scan_tick) begin
      presc_d     = '0;
      digit_sel_d = digit_sel_q + 2'd1;
    end
  end

  // The units digit is captured with tc at the frame boundary but only
  // shown once the tally conversion lands, so both switch together.
  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (frame_tick),
    .bin     (tc),
    .busy    (bin_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Output mux is driven from the next digit_sel so the registered
  // seg/an/dp line up with the digit_sel register itself.
  always_comb begin
    slot_val   = disp_units_q;
    slot_blank = 1'b0;
    dp_d       = 1'b1;
    case (digit_sel_d)
      2'd0: begin
        slot_val = disp_units_q;
        dp_d     = 1'b0;
      end
      2'd1: slot_val = disp_ones_q;
      2'd2: begin
        slot_val   = disp_tens_q;
        slot_blank = BLANK_LZ && (disp_hund_q == 4'd0) && (disp_tens_q == 4'd0);
      end
      default: begin
        slot_val   = disp_hund_q;
        slot_blank = BLANK_LZ && (disp_hund_q == 4'd0);
      end
    endcase
    an_d  = ~(4'b0001 << digit_sel_d);
    seg_d = seg_decode(slot_val);
    if (!en || slot_blank) begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      digit_sel_q   <= 2'd0;
      units_snap_q  <= '0;
      disp_units_q  <= '0;
      disp_ones_q   <= '0;
      disp_tens_q   <= '0;
      disp_hund_q   <= '0;
      value_valid_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= 4'hF;
    end else begin
      presc_q     <= presc_d;
      digit_sel_q <= digit_sel_d;
      if (frame_tick) begin
        units_snap_q <= count;
      end
      if (conv_done) begin
        disp_units_q  <= units_snap_q;
        disp_hund_q   <= conv_bcd[11:8];
        disp_tens_q   <= conv_bcd[7:4];
        disp_ones_q   <= conv_bcd[3:0];
        value_valid_q <= 1'b1;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign value_valid = value_valid_q;

endmodule
